// File: rtl/idu_queue.sv
// idu_queue: instruction-decode stage with a small circular instruction queue.
// Fetched {inst, pc} pairs are buffered between the IFU and the EXU. The head
// entry is decoded combinationally into opcode, register, immediate, system-op
// type and illegal-opcode fields. A redirect flush empties the queue in one cycle.
module idu_queue #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_inst,
  input  logic [PC_W-1:0] i_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [PC_W-1:0] o_pc,
  output logic [6:0]      o_op,
  output logic [2:0]      o_func,
  output logic [6:0]      o_func7,
  output logic [4:0]      o_reg_rd,
  output logic [4:0]      o_reg_rs1,
  output logic [4:0]      o_reg_rs2,
  output logic [31:0]     o_imm,
  output logic [2:0]      o_csr_t,
  output logic            o_illegal
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] CSR_MRET  = 3'b000;
  localparam logic [2:0] CSR_CSRW  = 3'b001;
  localparam logic [2:0] CSR_ECALL = 3'b011;
  localparam logic [2:0] CSR_NONE  = 3'b111;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_U,
    FMT_J,
    FMT_S,
    FMT_B,
    FMT_R,
    FMT_NONE
  } fmt_t;

  logic [31:0]     mem_inst [DEPTH];
  logic [PC_W-1:0] mem_pc   [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic full;
  logic empty;
  logic enq;
  logic deq;

  logic [31:0]     head_inst;
  logic [PC_W-1:0] head_pc;
  fmt_t            head_fmt;

  // Occupancy flags come straight from the registered count, so o_ready never
  // depends on the downstream handshake; a full queue refuses even when the
  // head is leaving this cycle.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign o_ready = !full && !i_reset;
  assign o_valid = !empty && !i_reset;
  assign enq     = i_valid && o_ready;
  assign deq     = o_valid && i_ready;

  // Queue state: reset clears storage to NOPs, flush only rewinds the pointers,
  // otherwise enqueue/dequeue advance their pointers and adjust the count.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst[i] <= NOP_INST;
        mem_pc[i]   <= '0;
      end
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        mem_inst[wr_ptr] <= i_inst;
        mem_pc[wr_ptr]   <= i_pc;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // An empty queue presents a NOP at pc 0 so the decode outputs stay in a
  // known, harmless state rather than showing a stale entry.
  always_comb begin
    head_inst = NOP_INST;
    head_pc   = '0;
    if (o_valid) begin
      head_inst = mem_inst[rd_ptr];
      head_pc   = mem_pc[rd_ptr];
    end
  end

  // Classify the head opcode into its immediate format.
  always_comb begin
    head_fmt = FMT_NONE;
    case (head_inst[6:0])
      OP_IMM, OP_JALR, OP_LOAD, OP_SYSTEM: head_fmt = FMT_I;
      OP_LUI, OP_AUIPC:                    head_fmt = FMT_U;
      OP_JAL:                              head_fmt = FMT_J;
      OP_STORE:                            head_fmt = FMT_S;
      OP_BRANCH:                           head_fmt = FMT_B;
      OP_REG:                              head_fmt = FMT_R;
      default:                             head_fmt = FMT_NONE;
    endcase
  end

  // Form the immediate for the head format; R-type and unknown opcodes give 0.
  always_comb begin
    o_imm = 32'h0;
    case (head_fmt)
      FMT_I: o_imm = {{20{head_inst[31]}}, head_inst[31:20]};
      FMT_U: o_imm = {head_inst[31:12], 12'h000};
      FMT_J: o_imm = {{12{head_inst[31]}}, head_inst[19:12], head_inst[20],
                      head_inst[30:21], 1'b0};
      FMT_S: o_imm = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
      FMT_B: o_imm = {{20{head_inst[31]}}, head_inst[7], head_inst[30:25],
                      head_inst[11:8], 1'b0};
      default: o_imm = 32'h0;
    endcase
  end

  // System-op type: func 000 splits MRET from ECALL on inst[21], any other
  // func is a CSR write, and non-system opcodes report NONE.
  always_comb begin
    o_csr_t = CSR_NONE;
    if (head_inst[6:0] == OP_SYSTEM) begin
      if (head_inst[14:12] == 3'b000) begin
        o_csr_t = head_inst[21] ? CSR_MRET : CSR_ECALL;
      end else begin
        o_csr_t = CSR_CSRW;
      end
    end
  end

  assign o_pc      = head_pc;
  assign o_op      = head_inst[6:0];
  assign o_func    = head_inst[14:12];
  assign o_func7   = head_inst[31:25];
  assign o_reg_rd  = head_inst[11:7];
  assign o_reg_rs1 = head_inst[19:15];
  assign o_reg_rs2 = head_inst[24:20];
  assign o_illegal = (head_fmt == FMT_NONE) && o_valid;

endmodule

// File: tb/tb_idu_queue.sv
// tb_idu_queue: directed bench for idu_queue. Each accepted instruction pushes
// its hand-derived expected decode onto a scoreboard; each dequeue pops and
// compares it against the head outputs.
module tb_idu_queue;

  localparam int DEPTH = 2;
  localparam int PC_W  = 32;

  logic            i_clock = 1'b0;
  logic            i_reset;
  logic            i_flush;
  logic            i_valid;
  logic            o_ready;
  logic [31:0]     i_inst;
  logic [PC_W-1:0] i_pc;
  logic            o_valid;
  logic            i_ready;
  logic [PC_W-1:0] o_pc;
  logic [6:0]      o_op;
  logic [2:0]      o_func;
  logic [6:0]      o_func7;
  logic [4:0]      o_reg_rd;
  logic [4:0]      o_reg_rs1;
  logic [4:0]      o_reg_rs2;
  logic [31:0]     o_imm;
  logic [2:0]      o_csr_t;
  logic            o_illegal;

  typedef struct {
    logic [31:0] pc;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  csr;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t pending;
  exp_t popped;
  int   checks    = 0;
  int   errors    = 0;
  int   deq_count = 0;

  idu_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_flush  (i_flush),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_inst   (i_inst),
    .i_pc     (i_pc),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_pc     (o_pc),
    .o_op     (o_op),
    .o_func   (o_func),
    .o_func7  (o_func7),
    .o_reg_rd (o_reg_rd),
    .o_reg_rs1(o_reg_rs1),
    .o_reg_rs2(o_reg_rs2),
    .o_imm    (o_imm),
    .o_csr_t  (o_csr_t),
    .o_illegal(o_illegal)
  );

  // Free-running 10 ns clock.
  always #5 i_clock = ~i_clock;

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] pc,
                               input logic [31:0] imm, input logic [2:0] csr,
                               input logic ill);
    i_valid = 1'b1;
    i_inst  = inst;
    i_pc    = pc;
    pending = '{pc: pc, op: inst[6:0], rd: inst[11:7], imm: imm, csr: csr, ill: ill};
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_inst  = 32'h0;
    i_pc    = '0;
  endtask

  // Resolve this cycle's handshakes against the scoreboard, then advance to
  // just after the next rising edge.
  task automatic cycle();
    #1;
    if (!i_reset && !i_flush && o_valid && i_ready) begin
      deq_count++;
      checkOutput("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        popped = sb.pop_front();
        checkOutput("deq_pc", o_pc, popped.pc);
        checkOutput("deq_op", 32'(o_op), 32'(popped.op));
        checkOutput("deq_rd", 32'(o_reg_rd), 32'(popped.rd));
        checkOutput("deq_imm", o_imm, popped.imm);
        checkOutput("deq_csr_t", 32'(o_csr_t), 32'(popped.csr));
        checkOutput("deq_illegal", 32'(o_illegal), 32'(popped.ill));
      end
    end
    if (!i_reset && !i_flush && i_valid && o_ready) begin
      sb.push_back(pending);
    end
    @(posedge i_clock);
    #2;
  endtask

  initial begin
    i_reset = 1'b1;
    i_flush = 1'b0;
    i_ready = 1'b0;
    idle();
    #1;
    checkOutput("reset_valid", 32'(o_valid), 32'd0);
    checkOutput("reset_ready", 32'(o_ready), 32'd0);
    cycle();
    cycle();
    i_reset = 1'b0;
    #1;
    checkOutput("post_reset_ready", 32'(o_ready), 32'd1);
    checkOutput("post_reset_valid", 32'(o_valid), 32'd0);
    checkOutput("empty_op", 32'(o_op), 32'h13);
    checkOutput("empty_imm", o_imm, 32'h0);
    checkOutput("empty_csr_t", 32'(o_csr_t), 32'h7);
    checkOutput("empty_illegal", 32'(o_illegal), 32'd0);
    checkOutput("empty_pc", o_pc, 32'h0);

    // Single enqueue of addi x1,x0,5 and its one-cycle latency.
    applyStimulus(32'h0050_0093, 32'h8000_0000, 32'd5, 3'b111, 1'b0);
    cycle();
    idle();
    #1;
    checkOutput("single_valid", 32'(o_valid), 32'd1);
    checkOutput("single_rd", 32'(o_reg_rd), 32'd1);
    checkOutput("single_imm", o_imm, 32'd5);
    i_ready = 1'b1;
    cycle();
    i_ready = 1'b0;

    // Fill and backpressure: third instruction waits until the head leaves.
    applyStimulus(32'h0010_0113, 32'h0000_0100, 32'd1, 3'b111, 1'b0);
    cycle();
    applyStimulus(32'h0020_0193, 32'h0000_0104, 32'd2, 3'b111, 1'b0);
    cycle();
    applyStimulus(32'h0030_0213, 32'h0000_0108, 32'd3, 3'b111, 1'b0);
    #1;
    checkOutput("full_ready", 32'(o_ready), 32'd0);
    checkOutput("stall_pc_a", o_pc, 32'h100);
    cycle();
    checkOutput("stall_pc_b", o_pc, 32'h100);
    checkOutput("stall_imm_b", o_imm, 32'd1);
    cycle();
    i_ready = 1'b1;
    cycle();
    cycle();
    idle();
    cycle();
    checkOutput("drained_valid", 32'(o_valid), 32'd0);
    checkOutput("drained_sb", 32'(sb.size()), 32'd0);

    // Immediate formats, system-op types and an illegal opcode, streamed.
    applyStimulus(32'hFE00_0EE3, 32'h0000_0200, 32'hFFFF_FFFC, 3'b111, 1'b0);
    cycle();
    applyStimulus(32'h0000_00EF, 32'h0000_0204, 32'h0000_0000, 3'b111, 1'b0);
    cycle();
    applyStimulus(32'h8000_02B7, 32'h0000_0208, 32'h8000_0000, 3'b111, 1'b0);
    cycle();
    applyStimulus(32'hFE11_2E23, 32'h0000_020C, 32'hFFFF_FFFC, 3'b111, 1'b0);
    cycle();
    applyStimulus(32'h3020_0073, 32'h0000_0210, 32'h0000_0302, 3'b000, 1'b0);
    cycle();
    applyStimulus(32'h0000_0073, 32'h0000_0214, 32'h0000_0000, 3'b011, 1'b0);
    cycle();
    applyStimulus(32'h3052_9073, 32'h0000_0218, 32'h0000_0305, 3'b001, 1'b0);
    cycle();
    applyStimulus(32'h0000_007F, 32'h0000_021C, 32'h0000_0000, 3'b111, 1'b1);
    cycle();
    idle();
    cycle();
    checkOutput("fmt_drained_valid", 32'(o_valid), 32'd0);
    checkOutput("fmt_drained_illegal", 32'(o_illegal), 32'd0);

    // Flush on a full queue with simultaneous enqueue and dequeue.
    i_ready = 1'b0;
    applyStimulus(32'h0010_0113, 32'h0000_0300, 32'd1, 3'b111, 1'b0);
    cycle();
    applyStimulus(32'h0020_0193, 32'h0000_0304, 32'd2, 3'b111, 1'b0);
    cycle();
    applyStimulus(32'h0030_0213, 32'h0000_0308, 32'd3, 3'b111, 1'b0);
    i_flush = 1'b1;
    i_ready = 1'b1;
    cycle();
    sb.delete();
    i_flush = 1'b0;
    i_ready = 1'b0;
    idle();
    #1;
    checkOutput("flush_valid", 32'(o_valid), 32'd0);
    checkOutput("flush_ready", 32'(o_ready), 32'd1);
    cycle();
    checkOutput("flush_no_accept", 32'(o_valid), 32'd0);

    // Eight back-to-back instructions with the EXU always ready.
    deq_count = 0;
    i_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(32'h0000_0013 | (32'(i + 1) << 7), 32'h0000_1000 + 32'(4 * i),
                    32'h0, 3'b111, 1'b0);
      cycle();
      checkOutput("stream_ready", 32'(o_ready), 32'd1);
    end
    idle();
    cycle();
    checkOutput("stream_deq_count", 32'(deq_count), 32'd8);
    checkOutput("stream_sb_empty", 32'(sb.size()), 32'd0);
    checkOutput("stream_valid", 32'(o_valid), 32'd0);

    // Reset asserted mid-stream wins over a pending enqueue.
    i_ready = 1'b0;
    applyStimulus(32'h0010_0113, 32'h0000_0400, 32'd1, 3'b111, 1'b0);
    cycle();
    i_reset = 1'b1;
    #1;
    checkOutput("midreset_valid", 32'(o_valid), 32'd0);
    checkOutput("midreset_ready", 32'(o_ready), 32'd0);
    cycle();
    i_reset = 1'b0;
    idle();
    sb.delete();
    #1;
    checkOutput("after_midreset_valid", 32'(o_valid), 32'd0);
    checkOutput("after_midreset_pc", o_pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
